if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of id_stage.

---
 rtl/if_pkg.sv | 34 +++
 rtl/if_stage_if.sv | 27 ++
 rtl/if_pc_gen.sv | 37 +++
 rtl/if_stage.sv | 152 +++++++++++++++
 tb/tb_if_stage.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage and its IF/ID consumer.
package if_pkg;

  // Fetch FSM states: request, one fetch outstanding, stalled response buffered, stale response pending
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  // addi x0,x0,0 is the canonical RV32I bubble
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IF/ID pipeline register contents as seen by id_stage
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_4;
    logic        valid;
  } if_id_t;

  // A response captured while the hazard unit is stalling
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_4;
  } hold_t;

  // Instruction fetches are always word aligned; low address bits are discarded
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response channel: one request valid/ready pair
// plus an in-order response strobe with its data.
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  // Fetch stage side
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Memory side
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_pc_gen.sv
// Program counter: holds the address of the next fetch, advances by 4 on an
// accepted request and jumps to the aligned redirect target on a flush.
module if_pc_gen
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  // Redirect beats sequential advance; +4 wraps naturally modulo 2^32
  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = align_word(redirect_pc);
    end else if (advance) begin
      pc_next = pc + 32'd4;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= align_word(RESET_PC);
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues in-order fetches (at most one outstanding),
// loads the IF/ID register, and honours hazard stalls and EX redirects.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  if_stage_if.master        imem,
  input  logic              stall_in,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc_4,
  output logic              if_id_valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc;
  logic [31:0]  req_pc_q;
  hold_t        hold_buf_q;
  logic         hold_vld_q;
  if_id_t       if_id_q;

  logic req_valid;
  logic req_fire;
  logic load_rsp;
  logic buffer_rsp;
  logic release_hold;

  if_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .advance        (req_fire),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a redirect flushes everything, leaving a stale fetch to drain if one is still in flight
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      if (state_q == S_WAIT && !imem.imem_rsp_valid) begin
        state_d = S_DROP;
      end else if (state_q == S_DROP && !imem.imem_rsp_valid) begin
        state_d = S_DROP;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      unique case (state_q)
        S_REQ:  if (req_fire) state_d = S_WAIT;
        S_WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (stall_in)      state_d = S_HOLD;
            else if (req_fire) state_d = S_WAIT;
            else               state_d = S_REQ;
          end
        end
        S_HOLD: if (!stall_in) state_d = S_REQ;
        S_DROP: if (imem.imem_rsp_valid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  // FSM outputs: request strobe and the datapath load enables
  always_comb begin
    req_valid    = 1'b0;
    load_rsp     = 1'b0;
    buffer_rsp   = 1'b0;
    release_hold = 1'b0;
    if (!redirect_valid) begin
      unique case (state_q)
        S_REQ:  req_valid = 1'b1;
        S_WAIT: begin
          load_rsp   = imem.imem_rsp_valid && !stall_in;
          buffer_rsp = imem.imem_rsp_valid && stall_in;
          req_valid  = imem.imem_rsp_valid && !stall_in;
        end
        S_HOLD: release_hold = hold_vld_q && !stall_in;
        S_DROP: req_valid = 1'b0;
        default: req_valid = 1'b0;
      endcase
    end
  end

  assign req_fire            = req_valid && imem.imem_req_ready;
  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = pc;

  // Remember which PC the outstanding fetch belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc_q <= align_word(RESET_PC);
    end else if (req_fire) begin
      req_pc_q <= pc;
    end
  end

  // Hold buffer: parks a response that arrived while the hazard unit was stalling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_buf_q <= '0;
      hold_vld_q <= 1'b0;
    end else if (redirect_valid || release_hold) begin
      hold_vld_q <= 1'b0;
    end else if (buffer_rsp) begin
      hold_buf_q <= '{instr: imem.imem_rsp_data, pc_4: req_pc_q + 32'd4};
      hold_vld_q <= 1'b1;
    end
  end

  // IF/ID register: flush on redirect, load new instructions, hold on stall, else bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q <= '{instr: NOP_INSTR, pc_4: 32'h0, valid: 1'b0};
    end else if (redirect_valid) begin
      if_id_q <= '{instr: NOP_INSTR, pc_4: 32'h0, valid: 1'b0};
    end else if (load_rsp) begin
      if_id_q <= '{instr: imem.imem_rsp_data, pc_4: req_pc_q + 32'd4, valid: 1'b1};
    end else if (release_hold) begin
      if_id_q <= '{instr: hold_buf_q.instr, pc_4: hold_buf_q.pc_4, valid: 1'b1};
    end else if (!stall_in) begin
      if_id_q.instr <= NOP_INSTR;
      if_id_q.valid <= 1'b0;
    end
  end

  assign if_id_instr = if_id_q.instr;
  assign if_id_pc_4  = if_id_q.pc_4;
  assign if_id_valid = if_id_q.valid;

  // Responses are only legal while a fetch is outstanding or being drained
  a_rsp_legal: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem.imem_rsp_valid && (state_q == S_REQ || state_q == S_HOLD)));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, backpressure, stall/hold, redirects,
// PC wrap-around and asynchronous reset mid-fetch.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_4;
  logic        if_id_valid;

  logic        w_stall_in;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_if_id_instr;
  logic [31:0] w_if_id_pc_4;
  logic        w_if_id_valid;

  int tests_run;
  int tests_failed;

  if_stage_if ifc();
  if_stage_if wifc();

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (ifc),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_4     (if_id_pc_4),
    .if_id_valid    (if_id_valid)
  );

  if_stage #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (wifc),
    .stall_in       (w_stall_in),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .if_id_instr    (w_if_id_instr),
    .if_id_pc_4     (w_if_id_pc_4),
    .if_id_valid    (w_if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_defaults();
    ifc.imem_req_ready  = 1'b1;
    ifc.imem_rsp_valid  = 1'b0;
    ifc.imem_rsp_data   = 32'h0;
    stall_in            = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = 32'h0;
    wifc.imem_req_ready = 1'b0;
    wifc.imem_rsp_valid = 1'b0;
    wifc.imem_rsp_data  = 32'h0;
    w_stall_in          = 1'b0;
    w_redirect_valid    = 1'b0;
    w_redirect_pc       = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_defaults();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (if_id_instr !== NOP) begin tests_failed++; $display("[TB] FAIL reset_instr: got %h expected %h", if_id_instr, NOP); end
    tests_run++;
    if (if_id_pc_4 !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pc_4: got %h expected %h", if_id_pc_4, 32'h0); end
    tests_run++;
    if (if_id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", if_id_valid); end
    tests_run++;
    if (ifc.imem_req_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_addr: got %h expected %h", ifc.imem_req_addr, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (ifc.imem_req_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_valid: got %b expected 1", ifc.imem_req_valid); end
  endtask

  task automatic test_streaming();
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      ifc.imem_rsp_valid = 1'b1;
      ifc.imem_rsp_data  = 32'hA000_0000 + i;
      #1;
      tests_run++;
      if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 32'(4 * (i + 1))) begin
        tests_failed++;
        $display("[TB] FAIL stream_req[%0d]: got valid=%b addr=%h expected valid=1 addr=%h", i, ifc.imem_req_valid, ifc.imem_req_addr, 32'(4 * (i + 1)));
      end
      step();
      tests_run++;
      if (if_id_instr !== 32'hA000_0000 + i || if_id_pc_4 !== 32'(4 * (i + 1)) || if_id_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL stream_ifid[%0d]: got %h/%h/%b expected %h/%h/1", i, if_id_instr, if_id_pc_4, if_id_valid, 32'hA000_0000 + i, 32'(4 * (i + 1)));
      end
    end
    ifc.imem_rsp_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    ifc.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 32'h0 || if_id_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL backpressure[%0d]: got valid=%b addr=%h ifid_valid=%b expected 1/0/0", i, ifc.imem_req_valid, ifc.imem_req_addr, if_id_valid);
      end
      step();
    end
    ifc.imem_req_ready = 1'b1;
    step();
    tests_run++;
    if (ifc.imem_req_valid !== 1'b0 || if_id_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_accept: got req_valid=%b ifid_valid=%b expected 0/0", ifc.imem_req_valid, if_id_valid);
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    step();
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'h1111_1111;
    stall_in           = 1'b1;
    #1;
    tests_run++;
    if (ifc.imem_req_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_rsp_req: got %b expected 0", ifc.imem_req_valid); end
    step();
    ifc.imem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (if_id_valid !== 1'b0 || ifc.imem_req_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold[%0d]: got ifid_valid=%b req_valid=%b expected 0/0", i, if_id_valid, ifc.imem_req_valid);
      end
      if (i == 1) stall_in = 1'b0;
      step();
    end
    tests_run++;
    if (if_id_instr !== 32'h1111_1111 || if_id_pc_4 !== 32'h4 || if_id_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got %h/%h/%b expected 11111111/00000004/1", if_id_instr, if_id_pc_4, if_id_valid);
    end
    tests_run++;
    if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 32'h4) begin
      tests_failed++;
      $display("[TB] FAIL stall_next_req: got valid=%b addr=%h expected 1/00000004", ifc.imem_req_valid, ifc.imem_req_addr);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step();
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'hB000_0000;
    step();
    ifc.imem_rsp_data  = 32'hB000_0004;
    step();
    ifc.imem_rsp_valid = 1'b0;
    redirect_valid     = 1'b1;
    redirect_pc        = 32'h0000_0103;
    #1;
    tests_run++;
    if (ifc.imem_req_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL redirect_no_req: got %b expected 0", ifc.imem_req_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    tests_run++;
    if (if_id_instr !== NOP || if_id_pc_4 !== 32'h0 || if_id_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL redirect_flush: got %h/%h/%b expected 00000013/00000000/0", if_id_instr, if_id_pc_4, if_id_valid);
    end
    tests_run++;
    if (ifc.imem_req_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL redirect_drop_req: got %b expected 0", ifc.imem_req_valid); end
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    ifc.imem_rsp_valid = 1'b0;
    #1;
    tests_run++;
    if (if_id_instr !== NOP || if_id_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL redirect_stale: got %h/%b expected 00000013/0", if_id_instr, if_id_valid);
    end
    tests_run++;
    if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 32'h0000_0100) begin
      tests_failed++;
      $display("[TB] FAIL redirect_target: got valid=%b addr=%h expected 1/00000100", ifc.imem_req_valid, ifc.imem_req_addr);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    step();
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'h3333_3333;
    step();
    tests_run++;
    if (if_id_instr !== 32'h3333_3333 || if_id_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rs_preload: got %h/%b expected 33333333/1", if_id_instr, if_id_valid);
    end
    ifc.imem_rsp_data = 32'h2222_2222;
    stall_in          = 1'b1;
    redirect_valid    = 1'b1;
    redirect_pc       = 32'h0000_0200;
    step();
    set_defaults();
    #1;
    tests_run++;
    if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
      tests_failed++;
      $display("[TB] FAIL rs_flush_wins: got %h/%b expected 00000013/0", if_id_instr, if_id_valid);
    end
    tests_run++;
    if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 32'h0000_0200) begin
      tests_failed++;
      $display("[TB] FAIL rs_target: got valid=%b addr=%h expected 1/00000200", ifc.imem_req_valid, ifc.imem_req_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    ifc.imem_req_ready  = 1'b0;
    wifc.imem_req_ready = 1'b1;
    #1;
    tests_run++;
    if (wifc.imem_req_valid !== 1'b1 || wifc.imem_req_addr !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("[TB] FAIL wrap_first: got valid=%b addr=%h expected 1/fffffffc", wifc.imem_req_valid, wifc.imem_req_addr);
    end
    step();
    wifc.imem_rsp_valid = 1'b1;
    wifc.imem_rsp_data  = 32'h4444_4444;
    #1;
    tests_run++;
    if (wifc.imem_req_valid !== 1'b1 || wifc.imem_req_addr !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_next_addr: got valid=%b addr=%h expected 1/00000000", wifc.imem_req_valid, wifc.imem_req_addr);
    end
    step();
    wifc.imem_rsp_valid = 1'b0;
    wifc.imem_req_ready = 1'b0;
    tests_run++;
    if (w_if_id_instr !== 32'h4444_4444 || w_if_id_pc_4 !== 32'h0 || w_if_id_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wrap_pc_4: got %h/%h/%b expected 44444444/00000000/1", w_if_id_instr, w_if_id_pc_4, w_if_id_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'h5555_5555;
    step();
    ifc.imem_rsp_valid = 1'b0;
    tests_run++;
    if (if_id_valid !== 1'b1 || if_id_pc_4 !== 32'h4) begin
      tests_failed++;
      $display("[TB] FAIL midrst_pre: got %h/%b expected 00000004/1", if_id_pc_4, if_id_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (if_id_instr !== NOP || if_id_pc_4 !== 32'h0 || if_id_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_ifid: got %h/%h/%b expected 00000013/00000000/0", if_id_instr, if_id_pc_4, if_id_valid);
    end
    tests_run++;
    if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_req: got valid=%b addr=%h expected 1/00000000", ifc.imem_req_valid, ifc.imem_req_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b1;
    set_defaults();
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall_hold();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
